// File: rtl/uart_rx.sv
// uart_rx: sampling UART receiver, 8N1, LSB first, static baud rate.
// Recovers bytes from the serial line and presents each as a one-cycle strobe;
// stop-bit framing errors are reported as a one-cycle pulse.
module uart_rx #(
    parameter int unsigned pTicksPerBaud = 217,
    parameter bit          pInvertData   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       stb,
    output logic       err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(pTicksPerBaud);
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(pTicksPerBaud / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pTicksPerBaud - 1);
    localparam logic [7:0]       DATA_MASK = {8{pInvertData}};

    // Reject baud divisors too small for a meaningful mid-bit sample.
    if (pTicksPerBaud < 4) begin : g_param_check
        $error("uart_rx: pTicksPerBaud must be 4 or more");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_e;

    state_e           state_q;
    logic [1:0]       rx_sync_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             stb_q;
    logic             err_q;
    logic             busy_q;

    logic             rx_s;
    logic [7:0]       shift_d;
    logic [7:0]       data_d;

    assign rx_s    = rx_sync_q[1];
    assign shift_d = {rx_s, shift_q[7:1]};
    assign data_d  = shift_q ^ DATA_MASK;

    assign data = data_q;
    assign stb  = stb_q;
    assign err  = err_q;
    assign busy = busy_q;

    // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx};
        end
    end

    // Frame FSM: baud counting, mid-bit sampling, and registered strobes/busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            stb_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    baud_cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_cnt_q == CNT_HALF) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        if (!rx_s) begin
                            state_q <= ST_DATA;
                        end else begin
                            // Start bit did not hold to mid-bit: treat as a glitch.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_cnt_q == CNT_LAST) begin
                        baud_cnt_q <= '0;
                        shift_q    <= shift_d;
                        bit_idx_q  <= bit_idx_q + IDX_W'(1);
                        if (bit_idx_q == IDX_W'(7)) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_cnt_q == CNT_LAST) begin
                        baud_cnt_q <= '0;
                        busy_q     <= 1'b0;
                        if (rx_s) begin
                            // Leave at mid-stop-bit so a back-to-back start edge is caught.
                            stb_q   <= 1'b1;
                            data_q  <= data_d;
                            state_q <= ST_IDLE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_BREAK;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    // Line held low after a bad stop bit: wait for it to return idle.
                    baud_cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    baud_cnt_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. Two receivers share one serial line,
// one taking bits as sampled and one complementing them.
module tb_uart_rx;

    localparam int unsigned T = 8;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data0, data1;
    logic       stb0, stb1, err0, err1, busy0, busy1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int stb_cnt0 = 0, stb_cnt1 = 0, err_cnt0 = 0, err_cnt1 = 0, both_cnt = 0;
    logic [7:0] last_data0 = 8'h00, last_data1 = 8'h00;
    int stb_cyc0 = 0, prev_stb_cyc0 = 0;

    uart_rx #(.pTicksPerBaud(T), .pInvertData(1'b0)) u_dut_plain (
        .clk(clk), .rst(rst), .rx(rx),
        .data(data0), .stb(stb0), .err(err0), .busy(busy0)
    );

    uart_rx #(.pTicksPerBaud(T), .pInvertData(1'b1)) u_dut_inv (
        .clk(clk), .rst(rst), .rx(rx),
        .data(data1), .stb(stb1), .err(err1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (stb0) begin
                stb_cnt0 = stb_cnt0 + 1;
                last_data0 = data0;
                prev_stb_cyc0 = stb_cyc0;
                stb_cyc0 = cyc;
            end
            if (stb1) begin
                stb_cnt1 = stb_cnt1 + 1;
                last_data1 = data1;
            end
            if (err0) err_cnt0 = err_cnt0 + 1;
            if (err1) err_cnt1 = err_cnt1 + 1;
            if ((stb0 && err0) || (stb1 && err1)) both_cnt = both_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        repeat (T) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (T) tick();
        end
        rx = stop_v;
        repeat (T) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) tick();
        n_cmp++; if (data0 !== 8'h00) begin n_bad++; $display("FAIL reset_data0: got %h want 00", data0); end
        n_cmp++; if (data1 !== 8'h00) begin n_bad++; $display("FAIL reset_data1: got %h want 00", data1); end
        n_cmp++; if ({stb0, err0, busy0, stb1, err1, busy1} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000000", {stb0, err0, busy0, stb1, err1, busy1});
        end
        rst = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_basic();
        send_frame(8'h55, 1'b1);
        repeat (4) tick();
        n_cmp++; if (stb_cnt0 !== 1) begin n_bad++; $display("FAIL basic_stb_cnt: got %0d want 1", stb_cnt0); end
        n_cmp++; if (last_data0 !== 8'h55) begin n_bad++; $display("FAIL basic_data: got %h want 55", last_data0); end
        n_cmp++; if (last_data1 !== 8'hAA) begin n_bad++; $display("FAIL basic_data_inv: got %h want aa", last_data1); end
        n_cmp++; if (err_cnt0 + err_cnt1 !== 0) begin n_bad++; $display("FAIL basic_err: got %0d want 0", err_cnt0 + err_cnt1); end
        n_cmp++; if (data0 !== 8'h55) begin n_bad++; $display("FAIL basic_data_hold: got %h want 55", data0); end
    endtask

    task automatic test_invert();
        send_frame(8'h5C, 1'b1);
        repeat (4) tick();
        n_cmp++; if (stb_cnt1 !== 2) begin n_bad++; $display("FAIL inv_stb_cnt: got %0d want 2", stb_cnt1); end
        n_cmp++; if (last_data1 !== 8'hA3) begin n_bad++; $display("FAIL inv_data: got %h want a3", last_data1); end
        n_cmp++; if (last_data0 !== 8'h5C) begin n_bad++; $display("FAIL inv_data_plain: got %h want 5c", last_data0); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 1'b1);
        n_cmp++; if (last_data0 !== 8'h00) begin n_bad++; $display("FAIL b2b_first: got %h want 00", last_data0); end
        send_frame(8'hFF, 1'b1);
        repeat (4) tick();
        n_cmp++; if (stb_cnt0 !== 4) begin n_bad++; $display("FAIL b2b_stb_cnt: got %0d want 4", stb_cnt0); end
        n_cmp++; if (last_data0 !== 8'hFF) begin n_bad++; $display("FAIL b2b_second: got %h want ff", last_data0); end
        n_cmp++; if (last_data1 !== 8'h00) begin n_bad++; $display("FAIL b2b_second_inv: got %h want 00", last_data1); end
        n_cmp++; if (stb_cyc0 - prev_stb_cyc0 !== 80) begin
            n_bad++; $display("FAIL b2b_spacing: got %0d want 80", stb_cyc0 - prev_stb_cyc0);
        end
    endtask

    task automatic test_glitch();
        int busy_cycles = 0;
        rx = 1'b0;
        tick(); if (busy0) busy_cycles++;
        tick(); if (busy0) busy_cycles++;
        rx = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy0) busy_cycles++;
        end
        n_cmp++; if (busy_cycles < 1 || busy_cycles > 5) begin
            n_bad++; $display("FAIL glitch_busy: got %0d cycles want 1..5", busy_cycles);
        end
        n_cmp++; if (stb_cnt0 !== 4 || stb_cnt1 !== 4) begin
            n_bad++; $display("FAIL glitch_stb: got %0d/%0d want 4/4", stb_cnt0, stb_cnt1);
        end
        n_cmp++; if (err_cnt0 !== 0 || err_cnt1 !== 0) begin
            n_bad++; $display("FAIL glitch_err: got %0d/%0d want 0/0", err_cnt0, err_cnt1);
        end
    endtask

    task automatic test_framing_error();
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (40) tick();
        n_cmp++; if (err_cnt0 !== 1 || err_cnt1 !== 1) begin
            n_bad++; $display("FAIL ferr_err_cnt: got %0d/%0d want 1/1", err_cnt0, err_cnt1);
        end
        n_cmp++; if (stb_cnt0 !== 4) begin n_bad++; $display("FAIL ferr_no_stb: got %0d want 4", stb_cnt0); end
        n_cmp++; if (data0 !== 8'hFF || data1 !== 8'h00) begin
            n_bad++; $display("FAIL ferr_data_hold: got %h/%h want ff/00", data0, data1);
        end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL ferr_break_busy: got %b want 0", busy0); end
        rx = 1'b1;
        repeat (10) tick();
        n_cmp++; if (err_cnt0 !== 1 || stb_cnt0 !== 4) begin
            n_bad++; $display("FAIL ferr_recover_quiet: got err %0d stb %0d want 1/4", err_cnt0, stb_cnt0);
        end
        send_frame(8'h12, 1'b1);
        repeat (4) tick();
        n_cmp++; if (stb_cnt0 !== 5) begin n_bad++; $display("FAIL ferr_next_stb: got %0d want 5", stb_cnt0); end
        n_cmp++; if (last_data0 !== 8'h12 || last_data1 !== 8'hED) begin
            n_bad++; $display("FAIL ferr_next_data: got %h/%h want 12/ed", last_data0, last_data1);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b = 8'h7E;
        rx = 1'b0;
        repeat (T) tick();
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (T) tick();
        end
        rx = b[4];
        repeat (3) tick();
        n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before: got %b want 1", busy0); end
        rx  = 1'b1;
        rst = 1'b1;
        tick();
        n_cmp++; if (data0 !== 8'h00 || data1 !== 8'h00) begin
            n_bad++; $display("FAIL midrst_data: got %h/%h want 00/00", data0, data1);
        end
        n_cmp++; if ({stb0, err0, busy0, stb1, err1, busy1} !== 6'b0) begin
            n_bad++; $display("FAIL midrst_flags: got %b want 000000", {stb0, err0, busy0, stb1, err1, busy1});
        end
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        n_cmp++; if (stb_cnt0 !== 5 || err_cnt0 !== 1) begin
            n_bad++; $display("FAIL midrst_quiet: got stb %0d err %0d want 5/1", stb_cnt0, err_cnt0);
        end
        send_frame(8'h7E, 1'b1);
        repeat (4) tick();
        n_cmp++; if (stb_cnt0 !== 6 || stb_cnt1 !== 6) begin
            n_bad++; $display("FAIL midrst_stb: got %0d/%0d want 6/6", stb_cnt0, stb_cnt1);
        end
        n_cmp++; if (last_data0 !== 8'h7E || last_data1 !== 8'h81) begin
            n_bad++; $display("FAIL midrst_data_after: got %h/%h want 7e/81", last_data0, last_data1);
        end
        n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL stb_err_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_basic();
        test_invert();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Sampling UART receiver with a static baud rate: 8 data bits, no parity, 1 stop bit, LSB first.
- Recovers bytes from the serial line driven by the team's UART transmitter (or an external host) and presents each byte as a single-cycle strobe.
- Sits directly downstream of the transmitter on the serial link, and upstream of the Wishbone-side RX buffer/register.

Parameters:
- pTicksPerBaud, 217, clk cycles per bit period; legal range is 4 or more (elaboration error below 4).
- pInvertData, 1, when 1 the recovered byte is the bitwise complement of the sampled data bits. This pairs with the team's transmitter, which drives complemented data bits. When 0, bits are taken as sampled.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rx  in  1  serial line, asynchronous to clk, idle high
- data  out  8  last received byte; updates only when stb is asserted
- stb  out  1  one-cycle pulse: data holds a new valid byte
- err  out  1  one-cycle pulse: framing error (stop bit sampled low)
- busy  out  1  high while a frame is in progress, from the START state through the STOP state

Behaviour:
- Input synchronizer: rx passes through 2 flops, both reset to 1. All logic uses the synchronized value rx_s. Input delay is 2 cycles.
- baud_cnt width is $clog2(pTicksPerBaud). baud_cnt never reaches pTicksPerBaud. It is cleared on every state change.
- bit_idx counts 0..7, 3 bits wide.
- IDLE:
  - baud_cnt = 0.
  - When rx_s == 0 -> START.
- START:
  - baud_cnt increments each cycle.
  - At baud_cnt == pTicksPerBaud/2 - 1 (integer division), sample rx_s.
  - If rx_s is 0 -> DATA, with bit_idx = 0.
  - If rx_s is 1 -> IDLE. This is a glitch: no stb, no err.
- DATA:
  - At baud_cnt == pTicksPerBaud - 1, shift rx_s into bit 7 of the shift register (right shift).
  - bit_idx++ on each sample; after the sample taken at bit_idx == 7 -> STOP.
  - Every sample point therefore lies at the mid-bit.
- STOP:
  - At baud_cnt == pTicksPerBaud - 1, sample rx_s.
  - If rx_s is 1: on the next cycle, stb = 1 and data = shift register, XORed with 8'hFF when pInvertData is set. State -> IDLE.
  - If rx_s is 0: on the next cycle, err = 1, data is unchanged, and state -> BREAK.
- BREAK:
  - Wait until rx_s == 1, then -> IDLE.
  - No start is detected while the line is held low.
- Return from STOP to IDLE happens at mid-stop-bit. A start edge arriving immediately after the stop bit is therefore caught, so back-to-back frames are supported.
- stb and err are never asserted in the same cycle. Each is high for exactly 1 cycle per frame.
- Reset (any state, mid-frame included):
  - state = IDLE; baud_cnt = 0; bit_idx = 0; shift register = 0; data = 0; stb = 0; err = 0; busy = 0; synchronizer = 1.
  - If the line is low on release, it is treated as a new start bit 2 cycles after release. A partial frame caught this way may produce err; this is accepted behaviour.
- Latency:
  - Start detection occurs 2 cycles (synchronizer) after the rx falling edge.
  - stb rises 1 cycle after the mid-stop sample.
- Invariants for formal:
  - state is legal.
  - baud_cnt < pTicksPerBaud.
  - In IDLE, baud_cnt == 0.
  - busy == (state is START, DATA or STOP).

Test Plan:
- pTicksPerBaud=8, pInvertData=0: drive frame 0x55 (start 0, bits 1,0,1,0..., stop 1) -> exactly one stb pulse, data=0x55, err never asserted.
- pTicksPerBaud=8, pInvertData=1: drive a frame whose data bits on the line are the complement of 0xA3 -> data=0xA3, stb once.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two stb pulses, data 0x00 then 0xFF, 80 cycles apart.
- Glitch: rx low for 2 cycles (shorter than 4) then high -> returns to IDLE, no stb, no err, busy high for at most 5 cycles.
- Framing error: frame 0x3C with stop bit 0, line held low 40 more cycles -> err pulses once, data retains its previous value, no new frame is detected until rx returns high. Then frame 0x12 -> stb, data=0x12.
- Reset asserted mid-data (after bit 3) -> all outputs 0 on the next cycle, no stb. A complete frame 0x7E after release -> stb, data=0x7E.
